// File: rtl/stage_sequencer.sv
// Multi-cycle instruction sequencer for the MIPS core.
// Walks each instruction through IF, ID, EX, optional MEM and WB, emitting
// one-cycle stage strobes plus memory, PC and register-file controls.
// A halt opcode parks the sequencer until reset.
module stage_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        IF,
  output logic        ID,
  output logic        EX,
  output logic        MEM,
  output logic        WB,
  output logic        pc_en,
  output logic        jr,
  output logic        IMEM_en,
  output logic        DMEM_en,
  output logic        dmem_we,
  output logic        reg_we,
  output logic        halted,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  // JR gets its own class so the WB decode needs no funct field.
  typedef enum logic [2:0] {
    C_RTYPE = 3'd0,
    C_JR    = 3'd1,
    C_LW    = 3'd2,
    C_SW    = 3'd3,
    C_BEQ   = 3'd4,
    C_J     = 3'd5,
    C_HALT  = 3'd6,
    C_IALU  = 3'd7
  } class_t;

  state_t      r_state;
  state_t      w_state_next;
  class_t      r_class;
  class_t      w_class;
  logic [31:0] r_retired;

  // Classify the opcode currently on the instruction bus.
  always_comb begin
    w_class = C_IALU;
    case (opcode)
      6'b000000: w_class = (funct == 6'b001000) ? C_JR : C_RTYPE;
      6'b100011: w_class = C_LW;
      6'b101011: w_class = C_SW;
      6'b000100: w_class = C_BEQ;
      6'b000010: w_class = C_J;
      6'b111111: w_class = C_HALT;
      default:   w_class = C_IALU;
    endcase
  end

  // State register; unused codes fall back to S_IF via the next-state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IF;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: every non-halt stage freezes while stall is high, and ready
  // seen during a stall is simply not acted on.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IF:    if (!stall && imem_ready) w_state_next = S_ID;
      S_ID:    if (!stall) w_state_next = (w_class == C_HALT) ? S_HALT : S_EX;
      S_EX:    if (!stall) w_state_next = (r_class == C_LW || r_class == C_SW) ? S_MEM : S_WB;
      S_MEM:   if (!stall && dmem_ready) w_state_next = S_WB;
      S_WB:    if (!stall) w_state_next = S_IF;
      S_HALT:  w_state_next = S_HALT;
      default: w_state_next = S_IF;
    endcase
  end

  // Latch the class as ID completes and count instructions as WB completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_class   <= C_IALU;
      r_retired <= 32'd0;
    end else begin
      if (r_state == S_ID && !stall) begin
        r_class <= w_class;
      end
      if (r_state == S_WB && !stall) begin
        r_retired <= r_retired + 32'd1;
      end
    end
  end

  // Output decode from state, latched class and stall; the ready inputs only
  // reach the IF and MEM strobes. Reset forces everything low.
  always_comb begin
    IF      = 1'b0;
    ID      = 1'b0;
    EX      = 1'b0;
    MEM     = 1'b0;
    WB      = 1'b0;
    pc_en   = 1'b0;
    jr      = 1'b0;
    IMEM_en = 1'b0;
    DMEM_en = 1'b0;
    dmem_we = 1'b0;
    reg_we  = 1'b0;
    halted  = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IF: begin
          IMEM_en = 1'b1;
          IF      = !stall && imem_ready;
        end
        S_ID: ID = !stall;
        S_EX: EX = !stall;
        S_MEM: begin
          DMEM_en = 1'b1;
          dmem_we = (r_class == C_SW);
          MEM     = !stall && dmem_ready;
        end
        S_WB: begin
          WB     = !stall;
          pc_en  = !stall;
          jr     = !stall && (r_class == C_JR);
          reg_we = !stall && (r_class == C_RTYPE || r_class == C_IALU || r_class == C_LW);
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign retired = rst ? 32'd0 : r_retired;

endmodule
